// File: rtl/mem_wb_stage_pkg.sv
// Shared core types for the MEM/WB boundary:
// writeback select, load funct3 codes, stage bundle.
package mem_wb_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_LD  = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] alu_data;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    wb_sel_e         wb_sel;
    logic [4:0]      rd_addr;
    logic            rd_wren;
    logic            valid;
    logic            misalign;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: memory-stage results in,
// writeback mux candidates and retire count out.
interface mem_wb_stage_if #(
  parameter int CNT_W = 32
);
  import mem_wb_stage_pkg::*;

  logic            i_stall;
  logic            i_flush;
  logic            i_valid;
  logic [XLEN-1:0] i_alu_data;
  logic [XLEN-1:0] i_lsu_raw;
  logic [1:0]      i_byte_off;
  logic [2:0]      i_ld_type;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_imm;
  logic [1:0]      i_wb_sel;
  logic [4:0]      i_rd_addr;
  logic            i_rd_wren;

  logic [XLEN-1:0] o_alu_data;
  logic [XLEN-1:0] o_ld_data;
  logic [XLEN-1:0] o_pc4;
  logic [XLEN-1:0] o_imm;
  logic [1:0]      o_wb_sel;
  logic [4:0]      o_rd_addr;
  logic            o_rd_wren;
  logic            o_valid;
  logic            o_misalign;
  logic [CNT_W-1:0] o_retire_cnt;

  modport master (
    output i_stall, i_flush, i_valid,
    output i_alu_data, i_lsu_raw,
    output i_byte_off, i_ld_type,
    output i_pc, i_imm, i_wb_sel,
    output i_rd_addr, i_rd_wren,
    input  o_alu_data, o_ld_data,
    input  o_pc4, o_imm, o_wb_sel,
    input  o_rd_addr, o_rd_wren,
    input  o_valid, o_misalign,
    input  o_retire_cnt
  );

  modport slave (
    input  i_stall, i_flush, i_valid,
    input  i_alu_data, i_lsu_raw,
    input  i_byte_off, i_ld_type,
    input  i_pc, i_imm, i_wb_sel,
    input  i_rd_addr, i_rd_wren,
    output o_alu_data, o_ld_data,
    output o_pc4, o_imm, o_wb_sel,
    output o_rd_addr, o_rd_wren,
    output o_valid, o_misalign,
    output o_retire_cnt
  );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load lane select, sign/zero extension and
// misaligned-load detection (combinational).
module mem_wb_stage_load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      ld_type,
  input  logic            valid,
  input  wb_sel_e         wb_sel,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic            bad_off;

  always_comb begin
    shifted  = raw >> {byte_off, 3'b000};
    lane_b   = shifted[7:0];
    lane_h   = byte_off[1] ? raw[31:16] : raw[15:0];
    data     = '0;
    bad_off  = 1'b0;
    unique case (1'b1)
      (ld_type == LD_LB):
        data = {{24{lane_b[7]}}, lane_b};
      (ld_type == LD_LBU):
        data = {24'b0, lane_b};
      (ld_type == LD_LH): begin
        data    = {{16{lane_h[15]}}, lane_h};
        bad_off = byte_off[0];
      end
      (ld_type == LD_LHU): begin
        data    = {16'b0, lane_h};
        bad_off = byte_off[0];
      end
      (ld_type == LD_LW): begin
        data    = raw;
        bad_off = |byte_off;
      end
      default: data = '0;
    endcase
    // only a real load instruction can fault
    misalign = valid && (wb_sel == WB_LD) && bad_off;
    if (misalign) data = '0;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures writeback
// candidates, qualifies rd write, counts retirements.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int          CNT_W  = 32,
  parameter int unsigned PC_INC = 4
)(
  input  logic           i_clk,
  input  logic           i_reset,
  mem_wb_stage_if.slave  bus
);

  mem_wb_t          r;
  mem_wb_t          nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  ld_data;
  logic             misalign;

  mem_wb_stage_load_extend u_ld (
    .raw      (bus.i_lsu_raw),
    .byte_off (bus.i_byte_off),
    .ld_type  (bus.i_ld_type),
    .valid    (bus.i_valid),
    .wb_sel   (wb_sel_e'(bus.i_wb_sel)),
    .data     (ld_data),
    .misalign (misalign)
  );

  always_comb begin
    nxt          = '0;
    nxt.alu_data = bus.i_alu_data;
    nxt.ld_data  = ld_data;
    nxt.pc4      = bus.i_pc + XLEN'(PC_INC);
    nxt.imm      = bus.i_imm;
    nxt.wb_sel   = wb_sel_e'(bus.i_wb_sel);
    nxt.rd_addr  = bus.i_rd_addr;
    nxt.rd_wren  = bus.i_valid
                 & bus.i_rd_wren
                 & (bus.i_rd_addr != 5'd0)
                 & ~misalign;
    nxt.valid    = bus.i_valid;
    nxt.misalign = misalign;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r   <= '0;
      cnt <= '0;
    end else if (bus.i_flush) begin
      r   <= '0;
    end else if (!bus.i_stall) begin
      r <= nxt;
      if (bus.i_valid && !misalign)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.o_alu_data   = r.alu_data;
  assign bus.o_ld_data    = r.ld_data;
  assign bus.o_pc4        = r.pc4;
  assign bus.o_imm        = r.imm;
  assign bus.o_wb_sel     = r.wb_sel;
  assign bus.o_rd_addr    = r.rd_addr;
  assign bus.o_rd_wren    = r.rd_wren;
  assign bus.o_valid      = r.valid;
  assign bus.o_misalign   = r.misalign;
  assign bus.o_retire_cnt = cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second
// instance with a 4-bit counter checks wrap.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.CNT_W(32)) bus_a ();
  mem_wb_stage_if #(.CNT_W(4))  bus_b ();

  mem_wb_stage #(.CNT_W(32), .PC_INC(4)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_a)
  );

  mem_wb_stage #(.CNT_W(4), .PC_INC(4)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_b)
  );

  assign bus_b.i_stall    = bus_a.i_stall;
  assign bus_b.i_flush    = bus_a.i_flush;
  assign bus_b.i_valid    = bus_a.i_valid;
  assign bus_b.i_alu_data = bus_a.i_alu_data;
  assign bus_b.i_lsu_raw  = bus_a.i_lsu_raw;
  assign bus_b.i_byte_off = bus_a.i_byte_off;
  assign bus_b.i_ld_type  = bus_a.i_ld_type;
  assign bus_b.i_pc       = bus_a.i_pc;
  assign bus_b.i_imm      = bus_a.i_imm;
  assign bus_b.i_wb_sel   = bus_a.i_wb_sel;
  assign bus_b.i_rd_addr  = bus_a.i_rd_addr;
  assign bus_b.i_rd_wren  = bus_a.i_rd_wren;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        valid,
    input logic [31:0] alu,
    input logic [31:0] raw,
    input logic [1:0]  off,
    input logic [2:0]  ld,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [1:0]  sel,
    input logic [4:0]  rd,
    input logic        wren
  );
    bus_a.i_valid    = valid;
    bus_a.i_alu_data = alu;
    bus_a.i_lsu_raw  = raw;
    bus_a.i_byte_off = off;
    bus_a.i_ld_type  = ld;
    bus_a.i_pc       = pc;
    bus_a.i_imm      = imm;
    bus_a.i_wb_sel   = sel;
    bus_a.i_rd_addr  = rd;
    bus_a.i_rd_wren  = wren;
  endtask

  task automatic test_reset();
    bus_a.i_stall = 1'b0;
    bus_a.i_flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h1111_2222,
          2'd0, LD_LW, 32'h100, 32'h55,
          2'b01, 5'd7, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bus_a.o_alu_data, bus_a.o_ld_data,
         bus_a.o_pc4, bus_a.o_imm} !== 128'd0)
      $display("FAIL reset_data got %h %h %h %h want 0",
               bus_a.o_alu_data, bus_a.o_ld_data,
               bus_a.o_pc4, bus_a.o_imm);
    else passed++;
    total++;
    if ({bus_a.o_wb_sel, bus_a.o_rd_addr,
         bus_a.o_rd_wren, bus_a.o_valid,
         bus_a.o_misalign} !== 10'd0)
      $display("FAIL reset_ctrl got sel=%b rd=%0d we=%b v=%b m=%b want 0",
               bus_a.o_wb_sel, bus_a.o_rd_addr,
               bus_a.o_rd_wren, bus_a.o_valid,
               bus_a.o_misalign);
    else passed++;
    total++;
    if (bus_a.o_retire_cnt !== 32'd0)
      $display("FAIL reset_cnt got %0d want 0",
               bus_a.o_retire_cnt);
    else passed++;
    rst = 1'b0;
    drive(1'b1, 32'h0000_00AA, 32'h0, 2'd0,
          LD_LW, 32'h200, 32'h0, 2'b00,
          5'd1, 1'b1);
    tick();
    total++;
    if (bus_a.o_retire_cnt !== 32'd1)
      $display("FAIL first_retire got %0d want 1",
               bus_a.o_retire_cnt);
    else passed++;
    total++;
    if (bus_a.o_alu_data !== 32'hAA ||
        bus_a.o_rd_wren !== 1'b1 ||
        bus_a.o_pc4 !== 32'h204)
      $display("FAIL first_capture got alu=%h we=%b pc4=%h want 000000aa 1 00000204",
               bus_a.o_alu_data, bus_a.o_rd_wren,
               bus_a.o_pc4);
    else passed++;
  endtask

  task automatic test_load();
    logic [31:0] exp_lb [4];
    exp_lb[0] = 32'hFFFF_FF82;
    exp_lb[1] = 32'h0000_007F;
    exp_lb[2] = 32'hFFFF_FFF1;
    exp_lb[3] = 32'hFFFF_FF80;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0, 32'h80F1_7F82, 2'(i),
            LD_LB, 32'h300, 32'h0, 2'b01,
            5'd5, 1'b1);
      tick();
      total++;
      if (bus_a.o_ld_data !== exp_lb[i] ||
          bus_a.o_misalign !== 1'b0)
        $display("FAIL lb_off%0d got %h m=%b want %h m=0",
                 i, bus_a.o_ld_data,
                 bus_a.o_misalign, exp_lb[i]);
      else passed++;
    end
    drive(1'b1, 32'h0, 32'h80F1_7F82, 2'd2,
          LD_LHU, 32'h300, 32'h0, 2'b01,
          5'd5, 1'b1);
    tick();
    total++;
    if (bus_a.o_ld_data !== 32'h0000_80F1)
      $display("FAIL lhu_off2 got %h want 000080f1",
               bus_a.o_ld_data);
    else passed++;
    drive(1'b1, 32'h0, 32'h80F1_7F82, 2'd0,
          LD_LH, 32'h300, 32'h0, 2'b01,
          5'd5, 1'b1);
    tick();
    total++;
    if (bus_a.o_ld_data !== 32'h0000_7F82 ||
        bus_a.o_rd_wren !== 1'b1)
      $display("FAIL lh_off0 got %h we=%b want 00007f82 1",
               bus_a.o_ld_data, bus_a.o_rd_wren);
    else passed++;
    drive(1'b1, 32'h0, 32'h80F1_7F82, 2'd0,
          LD_LW, 32'h300, 32'h0, 2'b01,
          5'd5, 1'b1);
    tick();
    total++;
    if (bus_a.o_ld_data !== 32'h80F1_7F82 ||
        bus_a.o_retire_cnt !== 32'd8)
      $display("FAIL lw_off0 got %h cnt=%0d want 80f17f82 8",
               bus_a.o_ld_data, bus_a.o_retire_cnt);
    else passed++;
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h0, 32'h80F1_7F82, 2'd1,
          LD_LW, 32'h400, 32'h0, 2'b01,
          5'd5, 1'b1);
    tick();
    total++;
    if (bus_a.o_misalign !== 1'b1 ||
        bus_a.o_rd_wren !== 1'b0 ||
        bus_a.o_ld_data !== 32'h0)
      $display("FAIL misalign_lw got m=%b we=%b ld=%h want 1 0 0",
               bus_a.o_misalign, bus_a.o_rd_wren,
               bus_a.o_ld_data);
    else passed++;
    total++;
    if (bus_a.o_retire_cnt !== 32'd8)
      $display("FAIL misalign_cnt got %0d want 8",
               bus_a.o_retire_cnt);
    else passed++;
    drive(1'b1, 32'h0, 32'h80F1_7F82, 2'd3,
          LD_LHU, 32'h400, 32'h0, 2'b01,
          5'd5, 1'b1);
    tick();
    total++;
    if (bus_a.o_misalign !== 1'b1 ||
        bus_a.o_rd_wren !== 1'b0)
      $display("FAIL misalign_lhu got m=%b we=%b want 1 0",
               bus_a.o_misalign, bus_a.o_rd_wren);
    else passed++;
    drive(1'b1, 32'h77, 32'h80F1_7F82, 2'd1,
          LD_LW, 32'h400, 32'h0, 2'b00,
          5'd5, 1'b1);
    tick();
    total++;
    if (bus_a.o_misalign !== 1'b0 ||
        bus_a.o_rd_wren !== 1'b1 ||
        bus_a.o_retire_cnt !== 32'd9)
      $display("FAIL misalign_nonload got m=%b we=%b cnt=%0d want 0 1 9",
               bus_a.o_misalign, bus_a.o_rd_wren,
               bus_a.o_retire_cnt);
    else passed++;
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h0000_1234, 32'h0, 2'd0,
          LD_LW, 32'h500, 32'h0, 2'b00,
          5'd3, 1'b1);
    tick();
    bus_a.i_stall = 1'b1;
    drive(1'b1, 32'h0000_5555, 32'h0, 2'd0,
          LD_LW, 32'h600, 32'h9, 2'b11,
          5'd4, 1'b1);
    tick();
    total++;
    if (bus_a.o_alu_data !== 32'h1234 ||
        bus_a.o_rd_addr !== 5'd3 ||
        bus_a.o_wb_sel !== 2'b00 ||
        bus_a.o_pc4 !== 32'h504)
      $display("FAIL stall_hold got alu=%h rd=%0d sel=%b pc4=%h want 00001234 3 00 00000504",
               bus_a.o_alu_data, bus_a.o_rd_addr,
               bus_a.o_wb_sel, bus_a.o_pc4);
    else passed++;
    total++;
    if (bus_a.o_retire_cnt !== 32'd10)
      $display("FAIL stall_cnt got %0d want 10",
               bus_a.o_retire_cnt);
    else passed++;
    bus_a.i_flush = 1'b1;
    tick();
    total++;
    if (bus_a.o_valid !== 1'b0 ||
        bus_a.o_rd_wren !== 1'b0 ||
        bus_a.o_alu_data !== 32'h0 ||
        bus_a.o_imm !== 32'h0)
      $display("FAIL flush_over_stall got v=%b we=%b alu=%h imm=%h want 0 0 0 0",
               bus_a.o_valid, bus_a.o_rd_wren,
               bus_a.o_alu_data, bus_a.o_imm);
    else passed++;
    total++;
    if (bus_a.o_retire_cnt !== 32'd10)
      $display("FAIL flush_cnt got %0d want 10",
               bus_a.o_retire_cnt);
    else passed++;
    bus_a.i_stall = 1'b0;
    bus_a.i_flush = 1'b0;
  endtask

  task automatic test_pc_wrap();
    drive(1'b1, 32'h0, 32'h0, 2'd0, LD_LW,
          32'hFFFF_FFFC, 32'hABCD_0000, 2'b10,
          5'd0, 1'b1);
    tick();
    total++;
    if (bus_a.o_pc4 !== 32'h0 ||
        bus_a.o_rd_wren !== 1'b0 ||
        bus_a.o_wb_sel !== 2'b10)
      $display("FAIL pc_wrap_x0 got pc4=%h we=%b sel=%b want 00000000 0 10",
               bus_a.o_pc4, bus_a.o_rd_wren,
               bus_a.o_wb_sel);
    else passed++;
    total++;
    if (bus_a.o_imm !== 32'hABCD_0000 ||
        bus_a.o_valid !== 1'b1 ||
        bus_a.o_retire_cnt !== 32'd11)
      $display("FAIL pc_wrap_misc got imm=%h v=%b cnt=%0d want abcd0000 1 11",
               bus_a.o_imm, bus_a.o_valid,
               bus_a.o_retire_cnt);
    else passed++;
    drive(1'b0, 32'h0, 32'h0, 2'd0, LD_LW,
          32'h10, 32'h0, 2'b00, 5'd9, 1'b1);
    tick();
    total++;
    if (bus_a.o_valid !== 1'b0 ||
        bus_a.o_rd_wren !== 1'b0 ||
        bus_a.o_retire_cnt !== 32'd11)
      $display("FAIL invalid_cap got v=%b we=%b cnt=%0d want 0 0 11",
               bus_a.o_valid, bus_a.o_rd_wren,
               bus_a.o_retire_cnt);
    else passed++;
  endtask

  task automatic test_cnt_wrap();
    bus_a.i_stall = 1'b1;
    bus_a.i_flush = 1'b1;
    rst = 1'b1;
    tick();
    total++;
    if (bus_a.o_valid !== 1'b0 ||
        bus_a.o_pc4 !== 32'h0 ||
        bus_a.o_retire_cnt !== 32'd0 ||
        bus_b.o_retire_cnt !== 4'd0)
      $display("FAIL reset_mid_stall got v=%b pc4=%h ca=%0d cb=%0d want 0 0 0 0",
               bus_a.o_valid, bus_a.o_pc4,
               bus_a.o_retire_cnt,
               bus_b.o_retire_cnt);
    else passed++;
    rst = 1'b0;
    bus_a.i_flush = 1'b0;
    bus_a.i_stall = 1'b0;
    drive(1'b1, 32'h1, 32'h0, 2'd0, LD_LW,
          32'h0, 32'h0, 2'b00, 5'd1, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (bus_b.o_retire_cnt !== 4'd15)
      $display("FAIL cnt4_at15 got %0d want 15",
               bus_b.o_retire_cnt);
    else passed++;
    bus_a.i_stall = 1'b1;
    tick();
    total++;
    if (bus_b.o_retire_cnt !== 4'd15)
      $display("FAIL cnt4_stall got %0d want 15",
               bus_b.o_retire_cnt);
    else passed++;
    bus_a.i_stall = 1'b0;
    tick();
    total++;
    if (bus_b.o_retire_cnt !== 4'd0 ||
        bus_a.o_retire_cnt !== 32'd16)
      $display("FAIL cnt_wrap got cb=%0d ca=%0d want 0 16",
               bus_b.o_retire_cnt,
               bus_a.o_retire_cnt);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_load();
    test_misalign();
    test_stall_flush();
    test_pc_wrap();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
